// File: rtl/bindct_pkg.sv
// Shared types and helpers for the 2D binDCT scheduler.
// Holds the FSM states, lane count and lane conversion functions.
package bindct_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ROW,
        COL,
        OUT
    } state_t;

    localparam int N = 8;

    // Clamp a signed value into a signed w-bit range.
    function automatic logic signed [31:0] sat_row(
        input logic signed [31:0] v,
        input int                 w
    );
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic logic signed [31:0] level_shift(
        input logic [31:0] p,
        input int          w,
        input logic        en
    );
        if (en) return $signed(p) - (32'sd1 <<< (w - 1));
        return $signed(p);
    endfunction

endpackage

// File: rtl/bindct_tbuf.sv
// 8x8 transpose buffer between the row and column passes.
// Rows are written whole; columns are read combinationally.
module bindct_tbuf
    import bindct_pkg::*;
#(
    parameter int ROW_W = 12
) (
    input  logic               clk,
    input  logic               we,
    input  logic [2:0]         widx,
    input  logic [N*ROW_W-1:0] wdata,
    input  logic [2:0]         ridx,
    output logic [N*ROW_W-1:0] rdata
);

    logic [N*ROW_W-1:0] row_q [N];

    always_ff @(posedge clk) begin
        if (we) row_q[widx] <= wdata;
    end

    always_comb begin
        rdata = '0;
        for (int r = 0; r < N; r++) begin
            rdata[r*ROW_W +: ROW_W] = row_q[r][int'(ridx)*ROW_W +: ROW_W];
        end
    end

endmodule

// File: rtl/bindct_2d_sched.sv
// Drives a shared 8-point binDCT core through row then column passes
// to produce an 8x8 2D forward DCT block.
module bindct_2d_sched
    import bindct_pkg::*;
#(
    parameter int PIX_W       = 8,
    parameter int ROW_W       = 12,
    parameter int OUT_W       = 16,
    parameter int LEVEL_SHIFT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [64*PIX_W-1:0]  blk_in,
    output logic                 core_in_valid,
    output logic [8*ROW_W-1:0]   core_in,
    input  logic                 core_out_valid,
    input  logic [8*OUT_W-1:0]   core_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [64*OUT_W-1:0]  coef_out,
    output logic                 err
);

    state_t state, state_n;
    logic [3:0] iss_cnt, cap_cnt;
    logic [64*PIX_W-1:0] pix_q;
    logic [64*OUT_W-1:0] coef_q;
    logic err_q;
    logic issue, capture, stray;
    logic [N*ROW_W-1:0] tb_wdata, tb_rdata;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        out_valid = 1'b0;
        issue    = 1'b0;
        capture  = 1'b0;
        stray    = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = !rst;
                stray    = core_out_valid;
                if (in_valid && in_ready) state_n = ROW;
            end
            ROW, COL: begin
                issue   = iss_cnt < 4'd8;
                capture = core_out_valid && (cap_cnt < iss_cnt);
                stray   = core_out_valid && !capture;
                if (capture && cap_cnt == 4'd7)
                    state_n = (state == ROW) ? COL : OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                stray     = core_out_valid;
                if (out_ready) state_n = IDLE;
            end
        endcase
    end

    assign core_in_valid = issue;

    always_comb begin
        core_in = '0;
        for (int c = 0; c < N; c++) begin
            if (state == ROW)
                core_in[c*ROW_W +: ROW_W] = ROW_W'(level_shift(
                    32'(pix_q[(int'(iss_cnt[2:0]) * N + c) * PIX_W +: PIX_W]),
                    PIX_W, LEVEL_SHIFT != 0));
            else
                core_in[c*ROW_W +: ROW_W] = tb_rdata[c*ROW_W +: ROW_W];
        end
    end

    always_comb begin
        tb_wdata = '0;
        for (int k = 0; k < N; k++) begin
            tb_wdata[k*ROW_W +: ROW_W] = ROW_W'(sat_row(
                32'(signed'(core_out[k*OUT_W +: OUT_W])), ROW_W));
        end
    end

    // Counters restart on every state change so each pass starts at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_cnt <= '0;
            cap_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state_n != state) begin
                iss_cnt <= '0;
                cap_cnt <= '0;
            end else begin
                if (issue)   iss_cnt <= iss_cnt + 4'd1;
                if (capture) cap_cnt <= cap_cnt + 4'd1;
            end
            if (stray) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state == IDLE && in_valid) pix_q <= blk_in;
        if (capture && state == COL) begin
            for (int k = 0; k < N; k++) begin
                coef_q[(k*N + int'(cap_cnt[2:0]))*OUT_W +: OUT_W]
                    <= core_out[k*OUT_W +: OUT_W];
            end
        end
    end

    bindct_tbuf #(
        .ROW_W (ROW_W)
    ) u_tbuf (
        .clk   (clk),
        .we    (capture && state == ROW),
        .widx  (cap_cnt[2:0]),
        .wdata (tb_wdata),
        .ridx  (iss_cnt[2:0]),
        .rdata (tb_rdata)
    );

    assign coef_out = coef_q;
    assign err      = err_q;

endmodule

// File: tb/tb_bindct_2d_sched.sv
// Scoreboard bench for bindct_2d_sched with a behavioural 1D core
// (per-lane multiply, truncated to OUT_W, configurable latency).
module tb_bindct_2d_sched;

    localparam int PIX_W = 8;
    localparam int ROW_W = 12;
    localparam int OUT_W = 16;
    localparam int BW    = 64*PIX_W;
    localparam int CW    = 64*OUT_W;

    typedef struct {
        logic [CW-1:0] coef;
        int            acc;
        int            lat;
    } exp_t;

    logic clk, rst;
    logic in_valid, in_ready;
    logic [BW-1:0] blk_in;
    logic core_in_valid;
    logic [8*ROW_W-1:0] core_in;
    logic core_out_valid;
    logic [8*OUT_W-1:0] core_out;
    logic out_valid, out_ready;
    logic [CW-1:0] coef_out;
    logic err;

    bindct_2d_sched #(
        .PIX_W (PIX_W), .ROW_W (ROW_W), .OUT_W (OUT_W), .LEVEL_SHIFT (1)
    ) dut (
        .clk (clk), .rst (rst),
        .in_valid (in_valid), .in_ready (in_ready), .blk_in (blk_in),
        .core_in_valid (core_in_valid), .core_in (core_in),
        .core_out_valid (core_out_valid), .core_out (core_out),
        .out_valid (out_valid), .out_ready (out_ready),
        .coef_out (coef_out), .err (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Behavioural core: lane * core_mul truncated to OUT_W, latency core_lat.
    int   core_lat = 3;
    int   core_mul = 1;
    logic inject   = 1'b0;
    logic pv [4];
    logic [8*OUT_W-1:0] pd [4];

    function automatic logic [8*OUT_W-1:0] core_fn(
        input logic [8*ROW_W-1:0] x, input int m);
        logic [8*OUT_W-1:0] r;
        logic signed [31:0] p;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            p = 32'(signed'(x[i*ROW_W +: ROW_W])) * m;
            r[i*OUT_W +: OUT_W] = p[OUT_W-1:0];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) pv[i] <= 1'b0;
        end else begin
            pv[0] <= core_in_valid;
            pd[0] <= core_fn(core_in, core_mul);
            for (int i = 1; i < 4; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    assign core_out_valid = pv[core_lat-1] | inject;
    assign core_out       = pd[core_lat-1];

    int nvec = 0;
    int nfail = 0;
    int done_cnt = 0;
    int n_push = 0;
    exp_t sb [$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        nvec++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    function automatic logic [BW-1:0] ramp_pix();
        logic [BW-1:0] b;
        for (int i = 0; i < 64; i++) b[i*PIX_W +: PIX_W] = 8'(i);
        return b;
    endfunction

    function automatic logic [BW-1:0] const_pix(input logic [7:0] v);
        logic [BW-1:0] b;
        for (int i = 0; i < 64; i++) b[i*PIX_W +: PIX_W] = v;
        return b;
    endfunction

    function automatic logic [CW-1:0] ramp_coef();
        logic [CW-1:0] c;
        for (int i = 0; i < 64; i++) c[i*OUT_W +: OUT_W] = 16'(i - 128);
        return c;
    endfunction

    function automatic logic [CW-1:0] const_coef(input logic [15:0] v);
        logic [CW-1:0] c;
        for (int i = 0; i < 64; i++) c[i*OUT_W +: OUT_W] = v;
        return c;
    endfunction

    // Monitor: latency on out_valid rise, coefficients on handshake.
    logic prev_ov = 1'b0;
    logic chk_ir  = 1'b0;
    always begin
        @(negedge clk);
        #1;
        if (rst) begin
            prev_ov = 1'b0;
            chk_ir  = 1'b0;
        end else begin
            if (chk_ir) begin
                chk("in_ready_after_out", 64'(in_ready), 64'd1);
                chk_ir = 1'b0;
            end
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) begin
                    nvec++; nfail++;
                    $display("FAIL unexpected_out_valid at cycle %0d", cyc);
                end else begin
                    chk("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
                end
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                exp_t e;
                int bad;
                e = sb.pop_front();
                bad = -1;
                nvec++;
                for (int i = 0; i < 64; i++)
                    if (bad < 0 && coef_out[i*OUT_W +: OUT_W]
                                   !== e.coef[i*OUT_W +: OUT_W]) bad = i;
                if (bad >= 0) begin
                    nfail++;
                    $display("FAIL coef blk%0d idx %0d: got %0d want %0d",
                             done_cnt, bad,
                             $signed(coef_out[bad*OUT_W +: OUT_W]),
                             $signed(e.coef[bad*OUT_W +: OUT_W]));
                end
                done_cnt++;
                chk_ir = 1'b1;
            end
            prev_ov = out_valid;
        end
    end

    // Entered and left at a negedge.
    task automatic send(input logic [BW-1:0] b, input logic [CW-1:0] c,
                        input bit push, input bit keep);
        int n;
        exp_t e;
        blk_in   = b;
        in_valid = 1'b1;
        n = 0;
        #1;
        while (!in_ready && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 400) begin
            nvec++; nfail++;
            $display("FAIL accept_timeout: got 0 want 1");
            in_valid = 1'b0;
            return;
        end
        chk("accept_order", 64'(done_cnt), 64'(n_push));
        if (push) begin
            e.coef = c;
            e.acc  = cyc;
            e.lat  = 17 + 2*core_lat;
            sb.push_back(e);
            n_push++;
        end
        @(negedge clk);
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", 64'(done_cnt >= target), 64'd1);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        blk_in    = '0;
        @(negedge clk); #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        chk("idle_out_valid", 64'(out_valid), 64'd0);
        chk("idle_core_in_valid", 64'(core_in_valid), 64'd0);
        chk("idle_err", 64'(err), 64'd0);
        @(negedge clk);

        // Ramp through identity core, L=3.
        core_lat = 3; core_mul = 1;
        send(ramp_pix(), ramp_coef(), 1, 0);
        wait_done(1);

        // All 255 with out_ready held low for 10 cycles.
        out_ready = 1'b0;
        send(const_pix(8'd255), const_coef(16'd127), 1, 0);
        begin
            int n;
            n = 0;
            #1;
            while (!out_valid && n < 100) begin
                @(negedge clk); #1;
                n++;
            end
            chk("hold_reach_out", 64'(out_valid), 64'd1);
            for (int i = 0; i < 10; i++) begin
                chk("hold_state",
                    {62'd0, out_valid, in_ready}, 64'd2);
                chk("hold_coef",
                    64'(coef_out == const_coef(16'd127)), 64'd1);
                @(negedge clk); #1;
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        wait_done(2);

        // x32 core, L=1: rows saturate, columns truncate to 16 bits.
        core_lat = 1; core_mul = 32;
        send(const_pix(8'd255), const_coef(16'hFFE0), 1, 0);
        wait_done(3);
        for (int r = 0; r < 8; r++)
            chk("tbuf_sat", 64'(dut.u_tbuf.row_q[r]), 64'({8{12'h7FF}}));

        // Reset during the column pass, then a mid-grey block.
        core_lat = 2; core_mul = 1;
        send(ramp_pix(), ramp_coef(), 0, 0);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        send(const_pix(8'd128), const_coef(16'd0), 1, 0);
        wait_done(4);

        // Back-to-back with in_valid held.
        core_lat = 3;
        send(ramp_pix(), ramp_coef(), 1, 1);
        send(const_pix(8'd255), const_coef(16'd127), 1, 0);
        wait_done(6);
        chk("err_clear", 64'(err), 64'd0);

        // Stray core result in IDLE sets sticky err.
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        #1;
        chk("err_set", 64'(err), 64'd1);
        @(negedge clk);
        send(ramp_pix(), ramp_coef(), 1, 0);
        wait_done(7);
        chk("err_sticky", 64'(err), 64'd1);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
